fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control FSM that sequences the 12-bit program counter through fetch, issue and update phases.
- Drives the PC load/increment controls and the load value, issues instruction-memory reads at the current PC, and holds the fetched instruction for the execute stage.
- Owns a small hardware return stack for call/return flow control, plus halt/resume and fault handling.
- Sits between the program counter, instruction memory and the execute unit.

Parameters:
- ADDR_W, 12, PC/address width; matches the program counter.
- INSTR_W, 16, instruction word width.
- STACK_DEPTH, 4, number of return-stack entries; must be at least 1.

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_PC  in  ADDR_W  current PC value from the program counter
- o_loadPC  out  1  PC load control
- o_incPC  out  1  PC increment control
- o_PCVal  out  ADDR_W  PC load value
- o_memReq  out  1  instruction read request
- o_memAddr  out  ADDR_W  read address; always equals i_PC
- i_memAck  in  1  read data valid this cycle
- i_memData  in  INSTR_W  read data
- o_IR  out  INSTR_W  latched instruction
- o_irValid  out  1  o_IR is valid for execute
- i_exDone  in  1  execute finished with the current instruction
- i_nextOp  in  2  flow op: 00 seq, 01 jump, 10 call, 11 return
- i_target  in  ADDR_W  jump/call target
- i_halt  in  1  halt after this instruction (sampled with i_exDone)
- i_resume  in  1  leave HALT
- o_fault  out  1  sticky stack overflow/underflow flag
- o_state  out  2  FSM state, for debug

Behaviour:
- Reset (i_rst_n=0, async), then on deassertion:
  - state=FETCH; o_IR=0; o_irValid=0; o_loadPC=0; o_incPC=0; o_PCVal=0; o_fault=0.
  - Stack pointer=0 (stack empty); stack contents don't-care.
- State encoding: FETCH=0, ISSUE=1, UPDATE=2, HALT=3.
- All outputs registered or decoded from state only. Exception: o_memAddr, which is a direct pass-through of i_PC.
- FETCH:
  - o_memReq=1. PC controls are 0, so the address stays stable.
  - Stay until i_memAck=1; an ack in the first FETCH cycle is legal.
  - On ack edge: o_IR<=i_memData, o_irValid<=1, go to ISSUE.
- ISSUE:
  - o_irValid=1, o_memReq=0. Wait for i_exDone.
  - On the i_exDone edge, decode i_nextOp, then go to UPDATE:
    - seq: schedule increment.
    - jump: schedule load of i_target.
    - call: if stack full, set fault (see below). Otherwise push i_PC+1 (mod 2^ADDR_W) and schedule load of i_target.
    - return: if stack empty, set fault (see below). Otherwise pop and schedule load of the popped value.
  - Fault path (call when full, or return when empty):
    - o_fault<=1, o_irValid<=0, go to HALT.
    - No PC update and no stack change.
    - Fault takes precedence over i_halt.
  - On every non-fault exit from ISSUE: o_irValid<=0.
- UPDATE (exactly 1 cycle):
  - o_incPC=1 (seq), or o_loadPC=1 with o_PCVal set (jump/call/return). Never both.
  - PC changes on the edge ending UPDATE.
  - Next state: HALT if i_halt was 1 when i_exDone was sampled, else FETCH.
- HALT:
  - All controls 0, o_irValid=0.
  - i_resume=1 with o_fault=0: go to FETCH.
  - With o_fault=1, i_resume is ignored; only reset clears the fault.
- Throughput: a zero-wait fetch with execute done at first ISSUE takes 3 cycles per instruction.
- o_PCVal holds its last loaded value outside UPDATE.
- i_exDone outside ISSUE and i_memAck outside FETCH are ignored.
- Wrap-around: call at PC=0xFFF pushes 0x000. PC wrap on increment is handled by the program counter.
- Reset mid-operation aborts immediately. Outputs go to reset values and the stack is emptied.

Test Plan:
- Sequential fetch: PC=0x000, mem ack after 2 wait cycles, data 0xA5A5, exDone seq -> o_memReq high 3 cycles; o_IR=0xA5A5 with o_irValid; single o_incPC pulse in UPDATE; next FETCH at 0x001.
- Jump: at PC=0x010, nextOp=01, target=0x3F0 -> one-cycle o_loadPC with o_PCVal=0x3F0; next o_memAddr=0x3F0; stack unchanged.
- Nested call/return, depth 4: call 0x100 from 0x005, call 0x200 from 0x100, then two returns -> loads 0x100, 0x200, 0x101, 0x006 in order; o_fault stays 0.
- Overflow: 4 calls, then a 5th call -> no o_loadPC/o_incPC; state=HALT; o_fault=1; i_resume has no effect. Underflow: return with empty stack -> same response.
- Halt/resume: exDone with i_halt=1, seq at PC=0x020 -> o_incPC pulse, then HALT. i_resume -> FETCH at 0x021.
- Reset mid-fetch: assert i_rst_n=0 while o_memReq is high with no ack -> all outputs go to reset values asynchronously; after release, state=FETCH, stack empty, o_fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch/issue/update sequencer for the program counter, with a small return
// stack for call/return and sticky fault on stack overflow or underflow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | instruction read pending at i_PC, waiting for i_memAck
// ISSUE  | o_IR valid for execute, waiting for i_exDone to decode flow op
// UPDATE | one-cycle PC increment or load pulse
// HALT   | idle; i_resume returns to FETCH unless a fault is latched
module fetch_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [ADDR_W-1:0]  i_PC,
    output logic               o_loadPC,
    output logic               o_incPC,
    output logic [ADDR_W-1:0]  o_PCVal,
    output logic               o_memReq,
    output logic [ADDR_W-1:0]  o_memAddr,
    input  logic               i_memAck,
    input  logic [INSTR_W-1:0] i_memData,
    output logic [INSTR_W-1:0] o_IR,
    output logic               o_irValid,
    input  logic               i_exDone,
    input  logic [1:0]         i_nextOp,
    input  logic [ADDR_W-1:0]  i_target,
    input  logic               i_halt,
    input  logic               i_resume,
    output logic               o_fault,
    output logic [1:0]         o_state
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] OP_SEQ  = 2'd0;
    localparam logic [1:0] OP_JUMP = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_UPDATE = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 fault_q, fault_d;
    logic [ADDR_W-1:0]    pcval_q, pcval_d;
    logic                 upd_load_q, upd_load_d;
    logic                 halt_pend_q, halt_pend_d;
    logic [SP_W-1:0]      sp_q, sp_d;

    logic [ADDR_W-1:0]    stack_q [STACK_DEPTH];
    logic                 push_en;
    logic [ADDR_W-1:0]    push_data;
    logic [IDX_W-1:0]     push_idx;
    logic [IDX_W-1:0]     pop_idx;
    logic [SP_W-1:0]      sp_m1;
    logic                 stack_full;
    logic                 stack_empty;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign sp_m1       = sp_q - SP_W'(1);
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_m1[IDX_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            pcval_q     <= '0;
            upd_load_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            sp_q        <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fault_q     <= fault_d;
            pcval_q     <= pcval_d;
            upd_load_q  <= upd_load_d;
            halt_pend_q <= halt_pend_d;
            sp_q        <= sp_d;
        end
    end

    // Stack contents need no reset; only the pointer defines what is live.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            stack_q[push_idx] <= push_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        fault_d     = fault_q;
        pcval_d     = pcval_q;
        upd_load_d  = upd_load_q;
        halt_pend_d = halt_pend_q;
        sp_d        = sp_q;
        push_en     = 1'b0;
        push_data   = i_PC + ADDR_W'(1);

        case (state_q)
            S_FETCH: begin
                if (i_memAck) begin
                    ir_d       = i_memData;
                    ir_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_exDone) begin
                    ir_valid_d  = 1'b0;
                    halt_pend_d = i_halt;
                    state_d     = S_UPDATE;
                    case (i_nextOp)
                        OP_SEQ: begin
                            upd_load_d = 1'b0;
                        end
                        OP_JUMP: begin
                            upd_load_d = 1'b1;
                            pcval_d    = i_target;
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                push_en    = 1'b1;
                                sp_d       = sp_q + SP_W'(1);
                                upd_load_d = 1'b1;
                                pcval_d    = i_target;
                            end
                        end
                        default: begin
                            if (stack_empty) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                sp_d       = sp_m1;
                                upd_load_d = 1'b1;
                                pcval_d    = stack_q[pop_idx];
                            end
                        end
                    endcase
                end
            end
            S_UPDATE: begin
                state_d = halt_pend_q ? S_HALT : S_FETCH;
            end
            default: begin
                // A latched fault pins the sequencer here until reset.
                if (i_resume && !fault_q) begin
                    state_d = S_FETCH;
                end
            end
        endcase
    end

    assign o_state   = state_q;
    assign o_memReq  = (state_q == S_FETCH);
    assign o_memAddr = i_PC;
    assign o_incPC   = (state_q == S_UPDATE) && !upd_load_q;
    assign o_loadPC  = (state_q == S_UPDATE) && upd_load_q;
    assign o_PCVal   = pcval_q;
    assign o_IR      = ir_q;
    assign o_irValid = ir_valid_q;
    assign o_fault   = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: acts as program counter, memory and execute unit;
// expected PC control pulses are queued at issue and matched when they appear.
module tb_fetch_sequencer;

    localparam int AW = 12;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic          loadPC, incPC;
    logic [AW-1:0] PCVal, memAddr, target;
    logic          memReq, memAck, irValid, exDone, halt, resume, fault;
    logic [IW-1:0] memData, IR;
    logic [1:0]    nextOp, state;

    always #10 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_PC(pc),
        .o_loadPC(loadPC), .o_incPC(incPC), .o_PCVal(PCVal),
        .o_memReq(memReq), .o_memAddr(memAddr),
        .i_memAck(memAck), .i_memData(memData),
        .o_IR(IR), .o_irValid(irValid),
        .i_exDone(exDone), .i_nextOp(nextOp), .i_target(target),
        .i_halt(halt), .i_resume(resume),
        .o_fault(fault), .o_state(state)
    );

    // Program counter driven by the sequencer's controls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc <= '0;
        else if (loadPC) pc <= PCVal;
        else if (incPC)  pc <= pc + 12'd1;
    end

    typedef struct packed {
        logic          load;
        logic [AW-1:0] val;
    } ctl_t;

    ctl_t          exp_q [$];
    logic [AW-1:0] stk [$];
    logic [AW-1:0] exp_pc;
    ctl_t          mon_e;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (loadPC || incPC)) begin
            chk("pc_ctl_excl", {31'b0, loadPC & incPC}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("pc_ctl_unexpected", exp_q.size(), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pc_ctl_kind", {31'b0, loadPC}, {31'b0, mon_e.load});
                if (mon_e.load) chk("pc_val", PCVal, mon_e.val);
            end
        end
    end

    task automatic do_fetch(input int nwait, input logic [IW-1:0] data);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk("fetch_state", state, 2'd0);
            chk("mem_req", memReq, 1'b1);
            chk("mem_addr", memAddr, exp_pc);
        end
        @(negedge clk);
        chk("mem_req", memReq, 1'b1);
        chk("mem_addr", memAddr, exp_pc);
        chk("fetch_no_ctl", {loadPC, incPC}, 2'b00);
        memAck  = 1'b1;
        memData = data;
        @(posedge clk);
        #1 memAck = 1'b0;
        @(negedge clk);
        chk("ir", IR, data);
        chk("ir_valid", irValid, 1'b1);
        chk("issue_state", state, 2'd1);
        chk("mem_req_issue", memReq, 1'b0);
    endtask

    task automatic do_issue(input logic [1:0] op, input logic [AW-1:0] tgt,
                            input logic hlt, input int exwait);
        bit            flt;
        ctl_t          e;
        logic [AW-1:0] nxt;
        for (int i = 0; i < exwait; i++) begin
            chk("issue_hold", state, 2'd1);
            chk("ir_valid_hold", irValid, 1'b1);
            @(negedge clk);
        end
        flt = 1'b0;
        e   = '0;
        nxt = exp_pc;
        case (op)
            2'd0: begin e.load = 1'b0; nxt = exp_pc + 12'd1; end
            2'd1: begin e.load = 1'b1; e.val = tgt; nxt = tgt; end
            2'd2: begin
                if (stk.size() >= 4) flt = 1'b1;
                else begin
                    stk.push_back(exp_pc + 12'd1);
                    e.load = 1'b1; e.val = tgt; nxt = tgt;
                end
            end
            default: begin
                if (stk.size() == 0) flt = 1'b1;
                else begin
                    nxt = stk.pop_back();
                    e.load = 1'b1; e.val = nxt;
                end
            end
        endcase
        if (!flt) exp_q.push_back(e);
        exDone = 1'b1; nextOp = op; target = tgt; halt = hlt;
        @(posedge clk);
        #1 exDone = 1'b0; halt = 1'b0;
        @(negedge clk);
        #1;
        if (flt) begin
            chk("fault_state", state, 2'd3);
            chk("fault_flag", fault, 1'b1);
            chk("fault_ir_valid", irValid, 1'b0);
            @(posedge clk);
            #1 chk("fault_stay", state, 2'd3);
        end else begin
            chk("update_state", state, 2'd2);
            chk("update_ir_valid", irValid, 1'b0);
            chk("ctl_seen", exp_q.size(), 32'd0);
            exp_pc = nxt;
            @(posedge clk);
            #1 chk("post_update_state", state, hlt ? 2'd3 : 2'd0);
        end
    endtask

    task automatic do_instr(input int nwait, input logic [IW-1:0] data, input logic [1:0] op,
                            input logic [AW-1:0] tgt, input logic hlt, input int exwait);
        do_fetch(nwait, data);
        do_issue(op, tgt, hlt, exwait);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        stk.delete();
        exp_q.delete();
        exp_pc = '0;
        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_ir", IR, 16'd0);
        chk("rst_ir_valid", irValid, 1'b0);
        chk("rst_ctl", {loadPC, incPC}, 2'b00);
        chk("rst_pcval", PCVal, 12'd0);
        chk("rst_fault", fault, 1'b0);
        #20 rst_n = 1'b1;
    endtask

    initial begin
        memAck = 0; memData = 0; exDone = 0; nextOp = 0; target = 0;
        halt = 0; resume = 0; exp_pc = '0;
        #35 rst_n = 1'b1;
        @(negedge clk);
        chk("init_state", state, 2'd0);
        chk("init_ir", IR, 16'd0);
        chk("init_ir_valid", irValid, 1'b0);
        chk("init_ctl", {loadPC, incPC}, 2'b00);
        chk("init_pcval", PCVal, 12'd0);
        chk("init_fault", fault, 1'b0);

        do_instr(2, 16'hA5A5, 2'd0, 12'h000, 1'b0, 0);
        do_instr(0, 16'h1234, 2'd1, 12'h010, 1'b0, 2);
        do_instr(1, 16'h5A5A, 2'd1, 12'h3F0, 1'b0, 0);
        chk("jump_stack", stk.size(), 32'd0);

        // nested call/return
        do_instr(0, 16'h0001, 2'd1, 12'h005, 1'b0, 0);
        do_instr(0, 16'h0002, 2'd2, 12'h100, 1'b0, 0);
        do_instr(1, 16'h0003, 2'd2, 12'h200, 1'b0, 1);
        do_instr(0, 16'h0004, 2'd3, 12'h000, 1'b0, 0);
        do_instr(0, 16'h0005, 2'd3, 12'h000, 1'b0, 0);
        chk("nested_pc", exp_pc, 12'h006);
        chk("nested_fault", fault, 1'b0);

        // wrap of pushed return address
        do_instr(0, 16'h0006, 2'd1, 12'hFFF, 1'b0, 0);
        do_instr(0, 16'h0007, 2'd2, 12'h050, 1'b0, 0);
        do_instr(0, 16'h0008, 2'd3, 12'h000, 1'b0, 0);

        // halt after seq, then resume
        do_instr(0, 16'h0009, 2'd1, 12'h020, 1'b0, 0);
        do_instr(0, 16'h000A, 2'd0, 12'h000, 1'b1, 0);
        for (int i = 0; i < 2; i++) begin
            memAck = 1'b1; exDone = 1'b1;
            @(negedge clk);
            chk("halt_hold", state, 2'd3);
            chk("halt_ctl", {loadPC, incPC, memReq, irValid}, 4'b0000);
        end
        memAck = 1'b0; exDone = 1'b0;
        resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        chk("resume_state", state, 2'd0);
        do_instr(0, 16'h000B, 2'd0, 12'h000, 1'b0, 0);
        chk("resume_pc", exp_pc, 12'h022);

        // overflow
        for (int i = 0; i < 4; i++) do_instr(0, 16'h0100, 2'd2, 12'h300 + 12'(i), 1'b0, 0);
        do_instr(0, 16'h0101, 2'd2, 12'h400, 1'b0, 0);
        resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ovf_resume_ignored", state, 2'd3);
            chk("ovf_fault_sticky", fault, 1'b1);
        end
        resume = 1'b0;

        // underflow
        apply_reset();
        do_instr(0, 16'h0200, 2'd3, 12'h000, 1'b0, 0);
        resume = 1'b1;
        @(negedge clk);
        chk("unf_resume_ignored", state, 2'd3);
        resume = 1'b0;

        // reset mid-fetch with a live stack entry
        apply_reset();
        do_instr(0, 16'h0300, 2'd2, 12'h400, 1'b0, 0);
        @(negedge clk);
        chk("midfetch_req", memReq, 1'b1);
        apply_reset();
        @(negedge clk);
        chk("post_rst_state", state, 2'd0);
        chk("post_rst_addr", memAddr, 12'h000);
        do_instr(0, 16'h0301, 2'd3, 12'h000, 1'b0, 0);

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
